// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter with a
//                start/busy/done handshake. The bcd output register holds its
//                value between conversions so downstream glyph renderers see
//                stable digits. Optional macro BCD_LEADING_BLANK_EN replaces
//                leading zero digits (never the ones digit) with code 4'hF.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  // Iteration counter only needs to reach WIDTH-1 before moving to LOAD.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // True when DIGITS decimal digits can represent every WIDTH-bit value.
  function automatic bit digits_sufficient(input int w, input int d);
    logic [255:0] pow10;
    logic [255:0] max_val;
    pow10   = 256'd1;
    for (int i = 0; i < d; i++) begin
      pow10 = pow10 * 256'd10;
    end
    max_val = (256'd1 << w) - 256'd1;
    return (pow10 > max_val);
  endfunction

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 4) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be at least 4");
  end
  if (!digits_sufficient(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [CNT_W-1:0]      r_cnt;

  // Scratch after the per-nibble "add 3 if >= 5" correction.
  logic [4*DIGITS-1:0]   w_adj;
  // Value written into bcd on the LOAD edge.
  logic [4*DIGITS-1:0]   w_load_val;

  // Per-digit double-dabble correction; the 4-bit add wraps within the nibble.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                              ? (r_scratch[4*gi +: 4] + 4'd3)
                              : r_scratch[4*gi +: 4];
  end

`ifdef BCD_LEADING_BLANK_EN
  // A digit is blanked when it and every digit above it are zero; the ones
  // digit is always shown so a zero input still displays "0".
  assign w_load_val[3:0] = r_scratch[3:0];
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign w_load_val[4*gi +: 4] = (r_scratch[4*DIGITS-1:4*gi] == '0)
                                   ? 4'hF
                                   : r_scratch[4*gi +: 4];
  end
`else
  // Leading zeros pass through unchanged.
  assign w_load_val = r_scratch;
`endif

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // {scratch, shift} shifts left by one after the correction step.
          r_scratch <= (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[WIDTH-1]};
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          bcd     <= w_load_val;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Scoreboard bench for bin_to_bcd_seq. Stimulus pushes the
//                expected bcd word; a monitor pops and compares on each done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clk;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [4*DIGITS-1:0] exp_q[$];

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference converter built from repeated division by ten.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          d[DIGITS];
    int                  rem;
    bit                  nz;
    rem = int'(v);
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = 4'(rem % 10);
      rem  = rem / 10;
    end
`ifdef BCD_LEADING_BLANK_EN
    nz = 1'b0;
    for (int i = DIGITS-1; i >= 1; i--) begin
      nz = nz | (d[i] != 4'd0);
      if (!nz) d[i] = 4'hF;
    end
`else
    nz = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = d[i];
    return r;
  endfunction

  // Monitor: compares outputs against the scoreboard and checks bcd stability.
  logic [4*DIGITS-1:0] prev_bcd;
  logic                prev_done;
  always @(negedge clk) begin
    if (rst) begin
      prev_bcd  = bcd;
      prev_done = 1'b0;
    end else begin
      checks++;
      if (bcd !== prev_bcd && done !== 1'b1) begin
        errors++;
        $display("FAIL bcd_stable: bcd changed to %h from %h without done", bcd, prev_bcd);
      end
      if (done === 1'b1) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_pulse: done high for more than one cycle");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got bcd %h with no conversion pending", bcd);
        end else begin
          logic [4*DIGITS-1:0] e;
          e = exp_q.pop_front();
          if (bcd !== e) begin
            errors++;
            $display("FAIL bcd_value: got %h expected %h", bcd, e);
          end
        end
`ifndef BCD_LEADING_BLANK_EN
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd[4*i +: 4] > 4'd9) begin
            errors++;
            $display("FAIL digit_range: digit %0d is %h in bcd %h", i, bcd[4*i +: 4], bcd);
          end
        end
`endif
      end
      prev_bcd  = bcd;
      prev_done = done;
    end
  end

  // Issue one request from IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] v, input logic [4*DIGITS-1:0] e, input bit expect_done);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    if (expect_done) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bin   = WIDTH'($urandom);
  endtask

  // Wait (bounded) for done at a negedge; reports the number of cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  initial begin
    int n;
    int t1;
    logic [WIDTH-1:0] v;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    rst = 1'b0;

    // Zero input, with latency check.
`ifdef BCD_LEADING_BLANK_EN
    issue(16'd0, 20'hFFFF0, 1'b1);
`else
    issue(16'd0, 20'h00000, 1'b1);
`endif
    wait_done(n);
    check("latency_zero", 32'(n), 32'd17);

    // Full-scale input; busy must be high for exactly 17 sampled cycles.
    issue(16'd65535, 20'h65535, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_cycles", 32'(n), 32'd17);
    check("busy_end_done", 32'(done), 32'd1);

    // A start during SHIFT must be ignored.
    issue(16'd12345, 20'h12345, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 16'd999;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (25) @(negedge clk);
    check("no_second_done_q", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second request held during the done cycle.
`ifdef BCD_LEADING_BLANK_EN
    issue(16'd42, 20'hFFF42, 1'b1);
`else
    issue(16'd42, 20'h00042, 1'b1);
`endif
    wait_done(n);
    t1    = cycle;
    start = 1'b1;
    bin   = 16'd7;
`ifdef BCD_LEADING_BLANK_EN
    exp_q.push_back(20'hFFFF7);
`else
    exp_q.push_back(20'h00007);
`endif
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("b2b_spacing", 32'(cycle - t1), 32'd18);

    // Reset during SHIFT aborts: no done, bcd cleared immediately.
    issue(16'd54321, 20'h0, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd",  32'(bcd),  32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(exp_q.size()), 32'd0);
    issue(16'd54321, 20'h54321, 1'b1);
    wait_done(n);

    // Random sweep against the reference converter.
    for (int k = 0; k < 2000; k++) begin
      v = WIDTH'($urandom);
      issue(v, ref_bcd(v), 1'b1);
      wait_done(n);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential double-dabble converter. It turns an unsigned binary result, such as a matrix-multiply output element, into packed BCD digits. Those digits feed the `bcd` inputs of the 8x16 glyph renderers on the VGA overlay. The converter holds its output register stable between conversions, so the renderers see glitch-free digits for a whole frame. The handshake is a simple start/busy/done, driven by the result-display controller.

## Interface
- `WIDTH`, 16, binary input width in bits (≥ 4).
- `DIGITS`, 5, number of BCD output digits. It must satisfy 10^DIGITS > 2^WIDTH − 1. The simulation check fires `$error` at elaboration if it does not.
- `clk`  input  1  system/pixel-domain clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a conversion; sampled only while idle.
- `bin`  input  WIDTH  unsigned value; sampled on the accepting edge only.
- `busy`  output  1  high while a conversion is in flight.
- `done`  output  1  one-cycle pulse; `bcd` is updated in the same cycle.
- `bcd`  output  4*DIGITS  packed digits; `bcd[3:0]` is the ones digit and `bcd[4*DIGITS-1:4*DIGITS-4]` is the most significant.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
- IDLE with `start`=1 on an edge:
  - copy `bin` into the shift register;
  - clear the BCD scratch register (4*DIGITS bits);
  - clear the iteration counter;
  - go to SHIFT and set `busy`.
- SHIFT, one iteration per edge:
  - every scratch nibble ≥ 5 gets +3 (4-bit add, no carry out of the nibble);
  - then the {scratch, shift} concatenation shifts left by 1, with a zero entering at the LSB;
  - the counter increments;
  - after exactly WIDTH iterations, go to LOAD.
- LOAD, one edge:
  - `bcd` ← scratch (post-processed per Configuration);
  - `done` ← 1, `busy` ← 0;
  - go to IDLE.
- `done` is a registered pulse and is cleared on every other edge.
- `start` during SHIFT or LOAD is ignored. There is no queueing and no error flag.
- `start` during the cycle `done`=1 is accepted, because the FSM is already in IDLE. Back-to-back conversions are therefore legal.
- `bcd` changes only on a LOAD edge or on reset. `bin` may change freely after the accepting edge.
- Every digit of `bcd` is 0–9, except for the blank code when the Configuration macro is enabled.

## Timing
- Accepting edge E0: `busy` = 1 from E0 onward.
- Shift edges: E1 … E_WIDTH.
- Load edge: E_(WIDTH+1). From this edge `bcd` is valid, `done` = 1 for exactly one cycle, and `busy` = 0.
- Latency is WIDTH+1 edges from acceptance to `done` (17 edges at default).
- Peak throughput is one conversion every WIDTH+2 cycles.
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, counter=0, scratch=0.
- Reset mid-conversion aborts immediately. `bcd` returns to 0 and no `done` pulse is produced.
- A simultaneous `rst` and `start`: reset wins and the request is dropped.

## Configuration
- Macro `BCD_LEADING_BLANK_EN`.
- Defined: in LOAD, every digit above the most significant nonzero digit is written as 4'hF instead of 0. The ones digit is never blanked, so an input of 0 yields blanks with a trailing "0". The glyph renderers draw code 4'hF as an empty cell.
- Undefined: leading zeros are output as 4'h0. No blanking logic is synthesized.

## Test plan
- `bin`=0, macro off → after 17 edges `done` pulses for exactly one cycle and `bcd`=20'h00000. With the macro on, `bcd`=20'hFFFF0.
- `bin`=65535 → `bcd`=20'h65535. `busy` is high for exactly 17 cycles starting at the accept edge.
- `bin`=12345, then `start` pulsed again with `bin`=999 during SHIFT → only one `done` pulse, with `bcd`=20'h12345. With the macro on, `bcd`=20'hF0345 is not expected here; the expected value is 20'h12345.
- Back-to-back: `bin`=42 converted, then `start` with `bin`=7 held during the `done` cycle → second `done` 18 cycles after the first. `bcd`=20'h00007 (macro on: 20'hFFFF7).
- Reset asserted at the 8th SHIFT edge of a 54321 conversion → `busy`=0, `bcd`=0 immediately, and no `done` pulse follows. A fresh 54321 request then produces 20'h54321.
- Random sweep: 2000 random 16-bit values, each checked against a reference converter. Every `bcd` digit is ≤ 9 (macro off), and `bcd` never changes except on a `done` cycle.
